piso_shift_tx: RTL and testbench
================================

// Module: piso_shift_tx
// PURPOSE
//   Parallel-in/serial-out transmitter: the read-out end of the team's parallel
//   D-register capture path. Accepts a WIDTH-bit word through a valid/ready load
//   handshake and emits it one bit per clk on ser_out, framed by ser_valid/ser_last.
//   Sits between a register/state bank and any 1-bit serial link or SIPO receiver.
// PARAMETERS
//   WIDTH      8   data word width in bits (>= 2)
//   LSB_FIRST  1   1: bit 0 sent first; 0: bit WIDTH-1 sent first
// PORTS
//   clk         in   1      rising-edge clock, single clock domain
//   reset       in   1      asynchronous, active-high reset
//   load_valid  in   1      load_data valid this cycle
//   load_data   in   WIDTH  word to transmit, sampled on accept edge
//   load_ready  out  1      block can accept a word this cycle
//   ser_out     out  1      current serial bit
//   ser_valid   out  1      ser_out holds a frame bit
//   ser_last    out  1      ser_out holds the final bit of the frame
//   busy        out  1      frame in progress (== ser_valid)
// BEHAVIOUR
//   - Reset (async, high): state=IDLE, shift reg=0, bit counter=0; outputs
//     ser_out=0, ser_valid=0, ser_last=0, busy=0, load_ready=1. Reset asserted
//     mid-frame aborts the frame immediately; no partial bits follow release.
//   - FSM: IDLE, SHIFT. All outputs registered except load_ready (combinational).
//   - load_ready = (state==IDLE) | (state==SHIFT & ser_last). Accept = load_valid & load_ready.
//   - IDLE: on accept, load shift reg with load_data, counter=0, go SHIFT.
//     load_valid with load_ready=0 is ignored (no buffering, no error flag).
//   - Latency: first bit on ser_out with ser_valid=1 in the cycle after the accept edge.
//   - SHIFT: one bit per clk; counter increments per bit; ser_last=1 exactly on
//     final frame bit (counter==FRAME-1). FRAME=WIDTH (see CONFIGURATION).
//   - End of frame: if accept during ser_last cycle -> reload, stay SHIFT, next
//     frame's first bit in the immediately following cycle (zero gap);
//     else -> IDLE, ser_valid/ser_last/ser_out return to 0.
//   - Shift direction per LSB_FIRST; vacated bits filled with 0.
//   - Counter width $clog2(FRAME+1); never wraps within a frame.
//   - load_data changes outside accept edge have no effect on an active frame.
// CONFIGURATION
//   PISO_PARITY_EN defined: one even-parity bit (XOR of all WIDTH data bits,
//     computed at accept) appended after the data; FRAME=WIDTH+1; ser_last
//     marks the parity bit; back-to-back reload window moves to that cycle.
//   PISO_PARITY_EN undefined: FRAME=WIDTH, no parity logic instantiated.
// TESTING (WIDTH=8, LSB_FIRST=1 unless noted)
//   1 Assert reset mid-sim -> all outputs 0 except load_ready=1, async (before next edge).
//   2 Accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8, ser_valid=1 cycles
//     1..8, ser_last only cycle 8, ser_valid=0 cycle 9. LSB_FIRST=0 -> 1,0,1,0,0,1,0,1 reversed order check with 8'h0F -> 0,0,0,0,1,1,1,1.
//   3 Accept 8'h0F, hold load_valid with 8'hF0 -> 16 contiguous ser_valid cycles,
//     ser_last on cycles 8 and 16, second word accepted only on cycle 8.
//   4 load_valid=1 data 8'hFF during bits 2..6 of frame 8'h00 -> ignored,
//     ser_out stays 0 all 8 bits, load_ready=0 those cycles.
//   5 Reset pulse during bit 3 of 8'hA5 -> outputs 0 at once; after release accept
//     8'h3C -> clean 8-bit frame 0,0,1,1,1,1,0,0.
//   6 PISO_PARITY_EN: accept 8'h07 -> 9-bit frame, bit 9 =1, ser_last on cycle 9;
//     8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// load port and emits it one bit per clk. Optional macro: PISO_PARITY_EN.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic             dbg_state
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

  // Handshake: a word moves when load_valid & load_ready are both high at a
  // rising clk edge; load_ready depends only on registered state, never on load_valid.

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [FRAME-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             out_nx, valid_nx, last_nx;
  logic [FRAME-1:0] frame_word;
  logic             accept;

  // The parity bit always follows the data, whichever end goes first.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (LSB_FIRST != 0) frame_word = {^load_data, load_data};
    else                frame_word = {load_data, ^load_data};
`else
    frame_word = load_data;
`endif
  end

  assign load_ready = (state == IDLE) || ((state == SHIFT) && ser_last);
  assign accept     = load_valid && load_ready;
  assign busy       = ser_valid;
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    out_nx   = ser_out;
    valid_nx = ser_valid;
    last_nx  = ser_last;
    if (accept) begin
      // sreg holds only the bits still to come; the first goes straight to ser_out.
      state_nx = SHIFT;
      cnt_nx   = '0;
      valid_nx = 1'b1;
      last_nx  = 1'b0;
      if (LSB_FIRST != 0) begin
        out_nx  = frame_word[0];
        sreg_nx = frame_word >> 1;
      end else begin
        out_nx  = frame_word[FRAME-1];
        sreg_nx = frame_word << 1;
      end
    end else if (state == SHIFT) begin
      if (ser_last) begin
        state_nx = IDLE;
        sreg_nx  = '0;
        cnt_nx   = '0;
        out_nx   = 1'b0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
      end else begin
        cnt_nx  = cnt + CW'(1);
        last_nx = (cnt_nx == LAST_IDX);
        if (LSB_FIRST != 0) begin
          out_nx  = sreg[0];
          sreg_nx = sreg >> 1;
        end else begin
          out_nx  = sreg[FRAME-1];
          sreg_nx = sreg << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      sreg      <= sreg_nx;
      cnt       <= cnt_nx;
      ser_out   <= out_nx;
      ser_valid <= valid_nx;
      ser_last  <= last_nx;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: LSB-first and MSB-first instances share the load
// port and are checked each cycle against queues of expected serial bits.
module tb_piso_shift_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         ready_l, out_l, valid_l, last_l, busy_l, dbg_l;
  logic         ready_m, out_m, valid_m, last_m, busy_m, dbg_m;

  int n_cmp = 0;
  int n_err = 0;
  bit q_l[$];
  bit q_m[$];

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready_l), .ser_out(out_l), .ser_valid(valid_l),
    .ser_last(last_l), .busy(busy_l), .dbg_state(dbg_l));

  piso_shift_tx #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready_m), .ser_out(out_m), .ser_valid(valid_m),
    .ser_last(last_m), .busy(busy_m), .dbg_state(dbg_m));

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset();
    check("rst_ready_l", ready_l, 1'b1);
    check("rst_out_l",   out_l,   1'b0);
    check("rst_valid_l", valid_l, 1'b0);
    check("rst_last_l",  last_l,  1'b0);
    check("rst_busy_l",  busy_l,  1'b0);
    check("rst_ready_m", ready_m, 1'b1);
    check("rst_out_m",   out_m,   1'b0);
    check("rst_valid_m", valid_m, 1'b0);
    check("rst_last_m",  last_m,  1'b0);
    check("rst_busy_m",  busy_m,  1'b0);
    q_l.delete();
    q_m.delete();
  endtask

  // Frame as the link should see it: data bits in send order, then even parity.
  task automatic push_frame(input logic [W-1:0] word);
    logic [W-1:0] w;
    w = word;
    for (int i = 0; i < W; i++) begin
      q_l.push_back(w[i]);
      q_m.push_back(w[W-1-i]);
    end
`ifdef PISO_PARITY_EN
    q_l.push_back(^w);
    q_m.push_back(^w);
`endif
  endtask

  // Called just after a falling edge with inputs already set: checks the
  // outputs of the current cycle, predicts the coming edge, then advances.
  task automatic tick();
    logic acc;
    check("valid_l", valid_l, q_l.size() != 0);
    check("busy_l",  busy_l,  q_l.size() != 0);
    check("last_l",  last_l,  q_l.size() == 1);
    check("out_l",   out_l,   (q_l.size() != 0) ? q_l[0] : 1'b0);
    check("ready_l", ready_l, q_l.size() <= 1);
    check("valid_m", valid_m, q_m.size() != 0);
    check("last_m",  last_m,  q_m.size() == 1);
    check("out_m",   out_m,   (q_m.size() != 0) ? q_m[0] : 1'b0);
    check("ready_m", ready_m, q_m.size() <= 1);
    acc = load_valid && (q_l.size() <= 1);
    if (q_l.size() != 0) void'(q_l.pop_front());
    if (q_m.size() != 0) void'(q_m.pop_front());
    if (acc) push_frame(load_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [W-1:0] word);
    load_valid = 1'b1;
    load_data  = word;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    pulse_reset();
    idle_cycles(2);

    // Single frame, then idle to see the frame close.
    send(8'hA5);
    idle_cycles(12);
    send(8'h0F);
    idle_cycles(12);

    // Held load_valid: second word taken only on the last bit of the first.
    load_valid = 1'b1;
    load_data  = 8'h0F;
    tick();
    load_data = 8'hF0;
    for (int i = 0; i < 8; i++) tick();
    idle_cycles(12);

    // load_valid during bits 2..6 of a frame must be ignored.
    send(8'h00);
    tick();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    idle_cycles(12);

    // Reset during bit 3 aborts the frame; next frame is clean.
    send(8'hA5);
    idle_cycles(2);
    pulse_reset();
    idle_cycles(2);
    send(8'h3C);
    idle_cycles(12);

    send(8'h07);
    idle_cycles(12);
    send(8'h03);
    idle_cycles(12);

    // Random traffic: bursty load_valid with random data, occasional reset.
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = W'($urandom);
      if ($urandom_range(0, 150) == 0) pulse_reset();
      else tick();
    end
    idle_cycles(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
